// File: rtl/row_feeder_pkg.sv
// Shared definitions for the row feeder: FSM state encoding and the
// per-row instruction encodings driven into the array.
package row_feeder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_LOAD = 2'b01;
  localparam logic [1:0] OP_EXEC = 2'b10;

  // A burst is only worth starting if it has an instruction and a length.
  function automatic logic burst_ok(logic [1:0] op, logic len_nz);
    return (op != OP_NOP) && len_nz;
  endfunction

endpackage

// File: rtl/feeder_fifo.sv
// Vector FIFO for the row feeder.
// Ports:
//   clk, reset : clock, asynchronous active-low reset (empties the FIFO)
//   wr, din    : push request and data; dropped when full unless a pop occurs too
//   rd, dout   : pop request and first-word-fall-through head data
//   full, empty: status derived from pointers with an extra wrap bit
module feeder_fifo
  import row_feeder_pkg::*;
#(
  parameter int unsigned width = 32,
  parameter int unsigned depth = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr,
  input  logic [width-1:0] din,
  input  logic             rd,
  output logic [width-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned aw = $clog2(depth);
  localparam int unsigned pw = aw + 1;

  logic [pw-1:0]    wptr_q, rptr_q;
  logic [width-1:0] mem [depth];
  logic             do_wr, do_rd;

  // Same index with opposite wrap bit means the write side lapped the read side.
  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[aw] != rptr_q[aw]) && (wptr_q[aw-1:0] == rptr_q[aw-1:0]);

  // A simultaneous pop frees a slot, so a push while full is still accepted.
  assign do_rd = rd && !empty;
  assign do_wr = wr && (!full || do_rd);

  assign dout = mem[rptr_q[aw-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_wr) wptr_q <= wptr_q + pw'(1);
      if (do_rd) rptr_q <= rptr_q + pw'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wptr_q[aw-1:0]] <= din;
  end

endmodule

// File: rtl/row_feeder.sv
// Row feeder: buffers input vectors and issues them as bursts onto the west
// edge of a systolic array, one row slice per array row.
// Ports:
//   clk, reset   : clock, asynchronous active-low reset
//   in, wr, full : vector input, push strobe, FIFO full
//   start, op,len: burst request (sampled in IDLE only), instruction, vector count
//   out_w, inst_w: per-row data and instruction to the array
//   busy, done   : not-IDLE flag, one-cycle burst-completion pulse
// Build option: define ROW_FEEDER_SKEW_EN to delay row r by r cycles (diagonal
// skew) and add a DRAIN phase of row-1 cycles; otherwise all rows share row-0
// timing and the burst ends directly from RUN.
module row_feeder
  import row_feeder_pkg::*;
#(
  parameter int unsigned bw    = 4,
  parameter int unsigned row   = 8,
  parameter int unsigned depth = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [bw*row-1:0]         in,
  input  logic                      wr,
  output logic                      full,
  input  logic                      start,
  input  logic [1:0]                op,
  input  logic [$clog2(depth):0]    len,
  output logic [bw*row-1:0]         out_w,
  output logic [2*row-1:0]          inst_w,
  output logic                      busy,
  output logic                      done
);

  localparam int unsigned lw = $clog2(depth) + 1;
  localparam int unsigned dw = (row > 1) ? $clog2(row) : 1;
`ifdef ROW_FEEDER_SKEW_EN
  localparam bit drain_en = (row > 1);
`else
  localparam bit drain_en = 1'b0;
`endif

  state_t            state_q;
  logic [1:0]        op_q;
  logic [lw-1:0]     rem_q;
  logic [dw-1:0]     drain_q;
  logic              busy_q, done_q;
  logic [bw*row-1:0] s0_data_q;
  logic [1:0]        s0_inst_q;

  logic [bw*row-1:0] fifo_dout;
  logic              fifo_empty;
  logic              pop;

  assign pop = (state_q == RUN) && !fifo_empty;

  feeder_fifo #(
    .width(bw * row),
    .depth(depth)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .wr   (wr),
    .din  (in),
    .rd   (pop),
    .dout (fifo_dout),
    .full (full),
    .empty(fifo_empty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      op_q      <= OP_NOP;
      rem_q     <= '0;
      drain_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      s0_data_q <= '0;
      s0_inst_q <= OP_NOP;
    end else begin
      done_q <= 1'b0;
      // Row-0 issue stage: a popped vector or a bubble.
      s0_data_q <= pop ? fifo_dout : '0;
      s0_inst_q <= pop ? op_q : OP_NOP;
      unique case (state_q)
        IDLE: begin
          if (start && burst_ok(op, len != '0)) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
            op_q    <= op;
            rem_q   <= len;
          end
        end
        RUN: begin
          if (pop) begin
            rem_q <= rem_q - lw'(1);
            if (rem_q == lw'(1)) begin
              if (drain_en) begin
                state_q <= DRAIN;
                drain_q <= dw'(row - 1);
              end else begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end
            end
          end
        end
        DRAIN: begin
          // Row 0 idles here while the skew stages of higher rows flush.
          drain_q <= drain_q - dw'(1);
          if (drain_q == dw'(1)) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;

  assign out_w[bw-1:0] = s0_data_q[bw-1:0];
  assign inst_w[1:0]   = s0_inst_q;

  for (genvar r = 1; r < row; r++) begin : g_row
`ifdef ROW_FEEDER_SKEW_EN
    // Row r sees its slice of the row-0 stream r cycles later.
    logic [bw-1:0] d_q [r];
    logic [1:0]    i_q [r];

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        for (int k = 0; k < r; k++) begin
          d_q[k] <= '0;
          i_q[k] <= OP_NOP;
        end
      end else begin
        d_q[0] <= s0_data_q[bw*r +: bw];
        i_q[0] <= s0_inst_q;
        for (int k = 1; k < r; k++) begin
          d_q[k] <= d_q[k-1];
          i_q[k] <= i_q[k-1];
        end
      end
    end

    assign out_w[bw*r +: bw] = d_q[r-1];
    assign inst_w[2*r +: 2]  = i_q[r-1];
`else
    assign out_w[bw*r +: bw] = s0_data_q[bw*r +: bw];
    assign inst_w[2*r +: 2]  = s0_inst_q;
`endif
  end

endmodule
